// File: rtl/clk_div_pkg.sv
// Shared constants, channel-index width helper and per-channel state record
// for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_RESET_DEFAULT = 16;
  localparam int DIV_W_DEFAULT     = 16;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Record layout at the default ratio width; channels re-declare it at their own DIV_W.
  typedef struct packed {
    logic [DIV_W_DEFAULT-1:0] cnt;
    logic [DIV_W_DEFAULT-1:0] active_div;
    logic [DIV_W_DEFAULT-1:0] pending_div;
    logic                     pending;
  } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: modulo-D counter, near-50% duty level, deferred ratio
// update at the terminal edge, and LOCKED tracking.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEFAULT,
  parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic             CLKIN,
  input  logic             RST_N,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o,
  output logic             clk_o,
  output logic             locked_o
);

  typedef struct packed {
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pending_div;
    logic             pending;
  } state_t;

  state_t st_q, st_d;
  logic   ce_q, ce_d;
  logic   clk_q, clk_d;
  logic   locked_q, locked_d;
  logic   run_q, run_d;
  logic   terminal;

  function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] d);
    return ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
  endfunction

  assign terminal = (st_q.cnt == st_q.active_div - DIV_W'(1));

  always_comb begin
    st_d     = st_q;
    ce_d     = 1'b0;
    clk_d    = clk_q;
    locked_d = locked_q;
    run_d    = run_q;
    if (sync_i) begin
      st_d.cnt = '0;
      run_d    = 1'b0;
      clk_d    = 1'b0;
      if (wr_i) begin
        st_d.active_div = div_i;
        st_d.pending    = 1'b0;
        locked_d        = 1'b0;
      end else if (st_q.pending) begin
        st_d.active_div = st_q.pending_div;
        st_d.pending    = 1'b0;
      end
    end else begin
      if (terminal) begin
        st_d.cnt = '0;
        ce_d     = 1'b1;
        clk_d    = 1'b1;
        run_d    = 1'b1;
        // The period that starts on a ratio switch must complete before LOCKED returns.
        if (st_q.pending) begin
          st_d.active_div = st_q.pending_div;
          st_d.pending    = 1'b0;
        end else begin
          locked_d = 1'b1;
        end
      end else begin
        st_d.cnt = st_q.cnt + DIV_W'(1);
        clk_d    = run_q && (({1'b0, st_q.cnt} + (DIV_W+1)'(1)) < high_len(st_q.active_div));
      end
      if (wr_i) begin
        st_d.pending_div = div_i;
        st_d.pending     = 1'b1;
        locked_d         = 1'b0;
      end
    end
  end

  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      st_q     <= '{cnt: '0, active_div: DIV_W'(DIV_RESET), pending_div: '0, pending: 1'b0};
      ce_q     <= 1'b0;
      clk_q    <= 1'b0;
      locked_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      ce_q     <= ce_d;
      clk_q    <= clk_d;
      locked_q <= locked_d;
      run_q    <= run_d;
    end
  end

  assign ce_o     = ce_q;
  assign clk_o    = clk_q;
  assign locked_o = locked_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: write decode, error flag and
// SYNC fan-out around NUM_CH independent divider channels.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = DIV_W_DEFAULT,
  parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic                        CLKIN,
  input  logic                        RST_N,
  input  logic                        SYNC,
  input  logic                        CFG_WE,
  input  logic [ch_idx_w(NUM_CH)-1:0] CFG_CH,
  input  logic [DIV_W-1:0]            CFG_DIV,
  output logic                        CFG_ERR,
  output logic [NUM_CH-1:0]           CE_OUT,
  output logic [NUM_CH-1:0]           CLK_OUT,
  output logic [NUM_CH-1:0]           LOCKED
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic accept;
  logic err_q, err_d;

  assign accept = CFG_WE && (32'(CFG_CH) < 32'(NUM_CH)) && (CFG_DIV != '0);
  assign err_d  = CFG_WE && !accept;

  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign CFG_ERR = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
    ) u_chan (
      .CLKIN    (CLKIN),
      .RST_N    (RST_N),
      .sync_i   (SYNC),
      .wr_i     (accept && (CFG_CH == CH_W'(i))),
      .div_i    (CFG_DIV),
      .ce_o     (CE_OUT[i]),
      .clk_o    (CLK_OUT[i]),
      .locked_o (LOCKED[i])
    );
  end

endmodule
